// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported, variable-latency memory between
// instruction fetch (I) and the memory stage (D). One access at a time:
// IDLE picks a winner and latches it, ISSUE strobes mem_en, WAIT holds the
// latched address/data until mem_done or timeout, HALT strobes mem_dump
// once and parks until reset.
// Optional build macro: ARB_RR_EN (alternate grants when both request;
// undefined gives fixed D-over-I priority).
//
// Handshake: a requester raises *_req and holds it, with its address and
// data, until it sees its one-cycle *_done pulse; *_stall = *_req & ~*_done.
// The done pulse is registered, so in the pulse cycle the requester's req is
// still high; that requester is masked out of arbitration for that cycle so
// a finished access is never re-granted.
module dmem_arbiter #(
  parameter int DW          = 16,
  parameter int AW          = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  output logic          i_stall,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  input  logic          halt,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_done,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_dump,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam int              TW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  state_t          state_q;
  logic            owner_is_d_q;  // 1 = D owns the access, 0 = I
  logic            wr_q;
  logic [TW-1:0]   timer_q;
  logic            i_done_q;
  logic            d_done_q;
  logic [DW-1:0]   i_rdata_q;
  logic [DW-1:0]   d_rdata_q;
  logic            mem_en_q;
  logic            mem_wr_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic            mem_dump_q;
  logic            err_q;
`ifdef ARB_RR_EN
  logic            last_is_d_q;   // 1 = last grant went to D
`endif

  logic i_pend;
  logic d_pend;
  logic d_wins;

  assign i_pend = i_req & ~i_done_q;
  assign d_pend = d_req & ~d_done_q;

  // Winner select for a grant in IDLE (only meaningful when a request is pending)
  always_comb begin
    d_wins = d_pend;
`ifdef ARB_RR_EN
    if (i_pend && d_pend) begin
      d_wins = ~last_is_d_q;
    end
`endif
  end

  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_stall   = i_req & ~i_done_q;
  assign d_stall   = d_req & ~d_done_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_dump  = mem_dump_q;
  assign err       = err_q;

  // Arbiter FSM with all outputs registered; strobes default low each cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_is_d_q <= 1'b1;
      wr_q         <= 1'b0;
      timer_q      <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_dump_q   <= 1'b0;
      err_q        <= 1'b0;
`ifdef ARB_RR_EN
      last_is_d_q  <= 1'b1;
`endif
    end else begin
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      mem_dump_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (halt) begin
            mem_dump_q <= 1'b1;
            state_q    <= HALT;
          end else if (i_pend || d_pend) begin
            owner_is_d_q <= d_wins;
`ifdef ARB_RR_EN
            last_is_d_q  <= d_wins;
`endif
            wr_q        <= d_wins & d_wr;
            mem_addr_q  <= d_wins ? d_addr : i_addr;
            mem_wdata_q <= d_wins ? d_wdata : '0;
            mem_en_q    <= 1'b1;
            mem_wr_q    <= d_wins & d_wr;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (mem_done) begin
            // Completion beats a coincident timeout
            if (owner_is_d_q) begin
              d_done_q <= 1'b1;
              if (!wr_q) d_rdata_q <= mem_rdata;
            end else begin
              i_done_q <= 1'b1;
              i_rdata_q <= mem_rdata;
            end
            state_q <= IDLE;
          end else if (timer_q == TIMER_LAST) begin
            // Abandon the access: flag it, release the owner, keep old rdata
            err_q <= 1'b1;
            if (owner_is_d_q) d_done_q <= 1'b1;
            else              i_done_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a behavioural memory responder answers
// each mem_en after a programmable latency, a monitor logs issued accesses,
// and each test task checks its own results inline.
module tb_dmem_arbiter;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int TO = 64;
  localparam logic [DW-1:0] KEY = 16'hC3C3;

  logic          clk;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_done;
  logic [DW-1:0] i_rdata;
  logic          i_stall;
  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          d_stall;
  logic          halt;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;
  logic          mem_dump;
  logic          err;

  dmem_arbiter #(.DW(DW), .AW(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
    .halt(halt),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_dump(mem_dump), .err(err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  // responder controls (written by tests only)
  int            resp_lat   = -1;   // cycles from mem_en to mem_done; <1 means never answer
  bit            resp_fixed = 1'b0;
  logic [DW-1:0] resp_data  = '0;
  int            stray_req  = 0;
  int            stray_ack  = 0;

  // monitor state (written by monitor only)
  int            en_cnt     = 0;
  int            i_done_cnt = 0;
  int            d_done_cnt = 0;
  int            dump_cnt   = 0;
  int            stab_bad   = 0;
  bit            busy       = 1'b0;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic [AW-1:0] act_addr_q[$];
  logic          act_wr_q[$];
  logic [DW-1:0] act_wdata_q[$];

  // expected issue order, filled by tests
  logic [AW-1:0] exp_q[$];

  // Memory responder: answers mem_en after resp_lat cycles, or fires a stray done
  initial begin
    logic [DW-1:0] rd;
    mem_done  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_en && resp_lat >= 1) begin
        rd = resp_fixed ? resp_data : (mem_addr ^ KEY);
        repeat (resp_lat) @(posedge clk);
        #1 mem_done = 1'b1;
        mem_rdata = rd;
        @(posedge clk);
        #1 mem_done = 1'b0;
        mem_rdata = '0;
      end else if (stray_req != stray_ack) begin
        @(posedge clk);
        #1 mem_done = 1'b1;
        mem_rdata = 16'hFFFF;
        @(posedge clk);
        #1 mem_done = 1'b0;
        mem_rdata = '0;
        stray_ack = stray_req;
      end
    end
  end

  // Monitor: logs issues, counts pulses, watches address/data stability
  always @(negedge clk) begin
    if (mem_en) begin
      en_cnt++;
      act_addr_q.push_back(mem_addr);
      act_wr_q.push_back(mem_wr);
      act_wdata_q.push_back(mem_wdata);
      busy      = 1'b1;
      cap_addr  = mem_addr;
      cap_wdata = mem_wdata;
    end else if (busy) begin
      if (rst || i_done || d_done) busy = 1'b0;
      else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata) stab_bad++;
    end
    if (i_done)   i_done_cnt++;
    if (d_done)   d_done_cnt++;
    if (mem_dump) dump_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input bit is_d, input int budget, output int n);
    n = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if ((is_d && d_done) || (!is_d && i_done)) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic wait_issue(input int base, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (en_cnt > base) break;
    end
  endtask

  task automatic d_access(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int lat, output int n);
    resp_lat = lat;
    @(posedge clk);
    #1 d_req = 1'b1; d_wr = wr; d_addr = a; d_wdata = wd;
    wait_done(1'b1, 100, n);
    @(posedge clk);
    #1 d_req = 1'b0; d_wr = 1'b0;
  endtask

  task automatic i_access(input logic [AW-1:0] a, input int lat, output int n);
    resp_lat = lat;
    @(posedge clk);
    #1 i_req = 1'b1; i_addr = a;
    wait_done(1'b0, 100, n);
    @(posedge clk);
    #1 i_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_en, mem_wr, mem_dump, i_done, d_done, err, i_stall, d_stall} !== 8'h00) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 00000000",
               {mem_en, mem_wr, mem_dump, i_done, d_done, err, i_stall, d_stall});
    end
    total++;
    if ({mem_addr, mem_wdata} !== 32'h0) begin
      bad++;
      $display("FAIL reset_mem: addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    total++;
    if ({i_rdata, d_rdata} !== 32'h0) begin
      bad++;
      $display("FAIL reset_rdata: i=%h d=%h want 0", i_rdata, d_rdata);
    end
  endtask

  task automatic test_single_read();
    int n, base, idx;
    resp_fixed = 1'b1; resp_data = 16'hBEEF; resp_lat = 3;
    base = en_cnt; idx = act_addr_q.size();
    @(posedge clk);
    #1 i_req = 1'b1; i_addr = 16'h0010;
    #2;
    total++;
    if (i_stall !== 1'b1) begin bad++; $display("FAIL rd_stall: got %b want 1", i_stall); end
    wait_done(1'b0, 40, n);
    total++;
    if (n !== 6) begin bad++; $display("FAIL rd_latency: got %0d want 6", n); end
    total++;
    if (i_rdata !== 16'hBEEF) begin bad++; $display("FAIL rd_data: got %h want beef", i_rdata); end
    total++;
    if (i_stall !== 1'b0) begin bad++; $display("FAIL rd_stall_done: got %b want 0", i_stall); end
    @(posedge clk);
    #1 i_req = 1'b0;
    @(negedge clk);
    total++;
    if (i_done !== 1'b0) begin bad++; $display("FAIL rd_pulse: got %b want 0", i_done); end
    repeat (3) @(negedge clk);
    total++;
    if (en_cnt - base !== 1) begin bad++; $display("FAIL rd_en_cnt: got %0d want 1", en_cnt - base); end
    total++;
    if (act_addr_q.size() <= idx || act_addr_q[idx] !== 16'h0010 || act_wr_q[idx] !== 1'b0) begin
      bad++;
      $display("FAIL rd_issue: size=%0d want addr 0010 wr 0", act_addr_q.size() - idx);
    end
  endtask

  task automatic test_write();
    int n, idx;
    resp_fixed = 1'b0;
    d_access(1'b0, 16'h0300, 16'h0000, 2, n);
    total++;
    if (n !== 5 || d_rdata !== (16'h0300 ^ KEY)) begin
      bad++;
      $display("FAIL d_read: n=%0d data=%h want n=5 data=%h", n, d_rdata, 16'h0300 ^ KEY);
    end
    idx = act_addr_q.size();
    resp_fixed = 1'b1; resp_data = 16'hDEAD;
    d_access(1'b1, 16'h0200, 16'h1234, 1, n);
    total++;
    if (n !== 4) begin bad++; $display("FAIL wr_latency: got %0d want 4", n); end
    total++;
    if (d_rdata !== (16'h0300 ^ KEY)) begin
      bad++;
      $display("FAIL wr_rdata_kept: got %h want %h", d_rdata, 16'h0300 ^ KEY);
    end
    total++;
    if (act_addr_q.size() <= idx || act_addr_q[idx] !== 16'h0200 || act_wr_q[idx] !== 1'b1 ||
        act_wdata_q[idx] !== 16'h1234) begin
      bad++;
      $display("FAIL wr_issue: want addr 0200 wr 1 wdata 1234 (entries %0d)", act_addr_q.size() - idx);
    end
    total++;
    if (i_rdata !== 16'hBEEF) begin bad++; $display("FAIL wr_i_rdata: got %h want beef", i_rdata); end
  endtask

  task automatic test_arbitration();
    bit first_d, got_i, got_d, first_seen, first_was_d;
    int stall_bad, idx, nbad;
    resp_fixed = 1'b0; resp_lat = 1;
`ifdef ARB_RR_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    exp_q.delete();
    if (first_d) begin exp_q.push_back(16'h0080); exp_q.push_back(16'h0040); end
    else         begin exp_q.push_back(16'h0040); exp_q.push_back(16'h0080); end
    idx = act_addr_q.size();
    got_i = 0; got_d = 0; first_seen = 0; first_was_d = 0; stall_bad = 0;
    @(posedge clk);
    #1 i_req = 1'b1; i_addr = 16'h0040; d_req = 1'b1; d_addr = 16'h0080; d_wr = 1'b0;
    for (int k = 0; k < 40 && !(got_i && got_d); k++) begin
      @(negedge clk);
      if (!first_seen && (first_d ? !i_stall : !d_stall)) stall_bad++;
      if (d_done && !got_d) begin
        got_d = 1;
        if (!first_seen) begin first_seen = 1; first_was_d = 1; end
      end
      if (i_done && !got_i) begin
        got_i = 1;
        if (!first_seen) begin first_seen = 1; first_was_d = 0; end
      end
      @(posedge clk);
      #1;
      if (got_d) d_req = 1'b0;
      if (got_i) i_req = 1'b0;
    end
    i_req = 1'b0; d_req = 1'b0;
    total++;
    if (!(got_i && got_d)) begin bad++; $display("FAIL arb_both_done: i=%b d=%b want 1 1", got_i, got_d); end
    total++;
    if (first_was_d !== first_d) begin
      bad++; $display("FAIL arb_order: first_d=%b want %b", first_was_d, first_d);
    end
    total++;
    if (stall_bad !== 0) begin bad++; $display("FAIL arb_loser_stall: %0d cycles unstalled want 0", stall_bad); end
    nbad = 0;
    for (int k = 0; k < 2; k++) begin
      if (act_addr_q.size() <= idx + k || act_addr_q[idx + k] !== exp_q[k]) nbad++;
    end
    total++;
    if (nbad !== 0) begin bad++; $display("FAIL arb_issue_seq: %0d wrong entries want 0", nbad); end
    total++;
    if (i_rdata !== (16'h0040 ^ KEY) || d_rdata !== (16'h0080 ^ KEY)) begin
      bad++;
      $display("FAIL arb_data: i=%h d=%h want %h %h", i_rdata, d_rdata, 16'h0040 ^ KEY, 16'h0080 ^ KEY);
    end
  endtask

  task automatic test_timeout();
    int n, early;
    resp_lat = -1;
    n = 0; early = 0;
    @(posedge clk);
    #1 i_req = 1'b1; i_addr = 16'h0050;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (i_done) begin n = k; break; end
      if (err) early++;
    end
    total++;
    if (n !== TO + 3) begin bad++; $display("FAIL to_latency: got %0d want %0d", n, TO + 3); end
    total++;
    if (err !== 1'b1 || early !== 0) begin
      bad++; $display("FAIL to_err: err=%b early=%0d want 1 0", err, early);
    end
    total++;
    if (i_rdata !== (16'h0040 ^ KEY)) begin
      bad++; $display("FAIL to_rdata_kept: got %h want %h", i_rdata, 16'h0040 ^ KEY);
    end
    @(posedge clk);
    #1 i_req = 1'b0;
    d_access(1'b0, 16'h0060, 16'h0000, 2, n);
    total++;
    if (n !== 5 || d_rdata !== (16'h0060 ^ KEY)) begin
      bad++; $display("FAIL to_recover: n=%0d data=%h want 5 %h", n, d_rdata, 16'h0060 ^ KEY);
    end
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", err); end
  endtask

  task automatic test_halt();
    int n, base, dbase;
    resp_fixed = 1'b0; resp_lat = 4;
    base = en_cnt; dbase = dump_cnt;
    @(posedge clk);
    #1 i_req = 1'b1; i_addr = 16'h0070;
    wait_issue(base, 20);
    @(posedge clk);
    #1 halt = 1'b1; d_req = 1'b1; d_addr = 16'h0099; d_wr = 1'b0;
    wait_done(1'b0, 40, n);
    total++;
    if (n == 0 || i_rdata !== (16'h0070 ^ KEY)) begin
      bad++; $display("FAIL halt_complete: n=%0d data=%h want %h", n, i_rdata, 16'h0070 ^ KEY);
    end
    repeat (10) @(negedge clk);
    total++;
    if (dump_cnt - dbase !== 1) begin bad++; $display("FAIL halt_dump: got %0d want 1", dump_cnt - dbase); end
    total++;
    if (en_cnt - base !== 1) begin bad++; $display("FAIL halt_no_grant: got %0d want 1", en_cnt - base); end
    total++;
    if (i_stall !== 1'b1 || d_stall !== 1'b1) begin
      bad++; $display("FAIL halt_stall: i=%b d=%b want 1 1", i_stall, d_stall);
    end
  endtask

  task automatic test_reset_in_wait();
    int n, base, dd;
    @(posedge clk);
    #1 rst = 1'b1; halt = 1'b0; i_req = 1'b0; d_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({err, mem_dump, i_rdata} !== 18'h0) begin
      bad++; $display("FAIL rst_from_halt: err=%b dump=%b i_rdata=%h want 0", err, mem_dump, i_rdata);
    end
    resp_lat = -1;
    base = en_cnt; dd = d_done_cnt;
    @(posedge clk);
    #1 d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0090; d_wdata = 16'h7777;
    wait_issue(base, 20);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; d_req = 1'b0; d_wr = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_en, mem_wr, d_done, i_done, err, mem_dump} !== 6'h0 ||
        mem_addr !== 16'h0 || mem_wdata !== 16'h0 || d_rdata !== 16'h0) begin
      bad++;
      $display("FAIL rst_wait_outs: ctl=%b addr=%h wdata=%h d_rdata=%h want 0",
               {mem_en, mem_wr, d_done, i_done, err, mem_dump}, mem_addr, mem_wdata, d_rdata);
    end
    repeat (5) @(negedge clk);
    total++;
    if (d_done_cnt !== dd) begin bad++; $display("FAIL rst_no_done: got %0d want %0d", d_done_cnt, dd); end
    i_access(16'h0011, 1, n);
    total++;
    if (n !== 4 || i_rdata !== (16'h0011 ^ KEY)) begin
      bad++; $display("FAIL rst_then_min_lat: n=%0d data=%h want 4 %h", n, i_rdata, 16'h0011 ^ KEY);
    end
  endtask

  task automatic test_stray_done();
    int base, id, dd;
    logic [DW-1:0] ir, dr;
    base = en_cnt; id = i_done_cnt; dd = d_done_cnt; ir = i_rdata; dr = d_rdata;
    stray_req++;
    repeat (5) @(negedge clk);
    total++;
    if (i_done_cnt !== id || d_done_cnt !== dd || en_cnt !== base || i_rdata !== ir || d_rdata !== dr) begin
      bad++;
      $display("FAIL stray_done: done %0d/%0d en %0d i=%h d=%h want unchanged",
               i_done_cnt - id, d_done_cnt - dd, en_cnt - base, i_rdata, d_rdata);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b1; halt = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    test_reset();
    test_single_read();
    test_write();
    test_arbitration();
    test_timeout();
    test_halt();
    test_reset_in_wait();
    test_stray_done();
    total++;
    if (stab_bad !== 0) begin bad++; $display("FAIL addr_stability: %0d changes want 0", stab_bad); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
